// File: rtl/par2ser_feeder_pkg.sv
// par2ser_feeder_pkg: shared FSM state type and default constants for the serialiser feeder
package par2ser_feeder_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDLE_BIT = 1;
endpackage

// File: rtl/p2s_hold_reg.sv
// p2s_hold_reg: one-entry holding buffer (data + full flag); ports clk/reset, load writes d, take empties, q/full out
module p2s_hold_reg
  import par2ser_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  always_ff @(posedge clk) begin
    full <= reset ? 1'b0 : load | (full & ~take);
    if (load) q <= d;
  end
endmodule

// File: rtl/par2ser_feeder.sv
// par2ser_feeder: word-to-bit serialiser; in_data/in_valid/in_ready accept side, ser_en/ser_out/ser_valid bit side, busy and words_sent status
module par2ser_feeder
  import par2ser_feeder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n, buf_data, sh_adv;
  logic [15:0] sent;
  logic full, take, inc, last;
  p2s_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk(clk), .reset(reset), .load(in_valid & in_ready), .take(take),
    .d(in_data), .q(buf_data), .full(full)
  );
  // ready depends only on the full flag and reset, never on in_valid
  assign in_ready = ~full & ~reset;
  assign last = cnt == CW'(WIDTH - 1);
  assign sh_adv = MSB_FIRST != 0 ? sh << 1 : sh >> 1;
  assign ser_valid = (state == SHIFT) & ser_en;
  assign ser_out = state == SHIFT ? (MSB_FIRST != 0 ? sh[WIDTH-1] : sh[0]) : 1'(IDLE_BIT);
  assign busy = (state == SHIFT) | full;
  assign words_sent = sent;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    take = 1'b0;
    inc = 1'b0;
    if (state == IDLE) begin
      if (full) begin
        take = 1'b1;
        sh_n = buf_data;
        cnt_n = '0;
        state_n = SHIFT;
      end
    end else if (ser_en) begin
      cnt_n = last ? '0 : cnt + 1'b1;
      inc = last;
      take = last & full;
      sh_n = last & full ? buf_data : sh_adv;
      state_n = last & ~full ? IDLE : SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_n;
    cnt <= reset ? '0 : cnt_n;
    sent <= reset ? '0 : sent + 16'(inc);
    sh <= sh_n;
  end
endmodule

// File: tb/tb_par2ser_feeder.sv
// tb_par2ser_feeder: directed and randomized checks of par2ser_feeder against a word-queue bit-stream model
module tb_par2ser_feeder;
  logic clk = 1'b0, reset, in_valid, ser_en;
  logic [7:0] in_data;
  logic in_ready, ser_out, ser_valid, busy;
  logic in_ready_l, ser_out_l, ser_valid_l, busy_l;
  logic [15:0] words_sent, words_sent_l;
  int total = 0, bad = 0, cyc = 0, acc;
  logic bq[$], lq[$];
  int cq[$];
  logic [7:0] wq[$];
  logic [7:0] w;
  par2ser_feeder dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_en(ser_en), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .words_sent(words_sent)
  );
  par2ser_feeder #(.MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .ser_en(ser_en), .ser_out(ser_out_l), .ser_valid(ser_valid_l), .busy(busy_l), .words_sent(words_sent_l)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (ser_valid) begin
      bq.push_back(ser_out);
      cq.push_back(cyc);
    end
    if (ser_valid_l) lq.push_back(ser_out_l);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clr;
    bq.delete();
    lq.delete();
    cq.delete();
    wq.delete();
  endtask
  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    ser_en = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    clr;
  endtask
  task automatic send(input logic [7:0] x);
    logic r, done;
    done = 1'b0;
    in_data = x;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      r = in_ready;
      tick;
      done = r;
    end
    in_valid = 1'b0;
    if (done) wq.push_back(x);
    else chk("send_timeout", 0, 1);
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 400 && (busy || ser_valid); i++) tick;
    chk("idle_busy", busy, 0);
  endtask
  task automatic chk_stream(input string tag);
    int m, ml;
    logic [7:0] x;
    m = 0;
    ml = 0;
    for (int k = 0; k < wq.size(); k++) begin
      x = wq[k];
      for (int j = 0; j < 8; j++) begin
        if (bq.size() > k * 8 + j && bq[k*8+j] !== x[7-j]) m++;
        if (lq.size() > k * 8 + j && lq[k*8+j] !== x[j]) ml++;
      end
    end
    chk({tag, "_msb_len"}, bq.size(), wq.size() * 8);
    chk({tag, "_msb_bits"}, m, 0);
    chk({tag, "_lsb_len"}, lq.size(), wq.size() * 8);
    chk({tag, "_lsb_bits"}, ml, 0);
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    ser_en = 1'b1;
    tick;
    tick;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_out", ser_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sent", words_sent, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    clr;
    w = 8'hB3;
    send(w);
    chk("b3_wait_valid", ser_valid, 0);
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("b3_valid", ser_valid, 1);
      chk("b3_bit", ser_out, w[7-i]);
      tick;
    end
    chk("b3_end_valid", ser_valid, 0);
    chk("b3_end_out", ser_out, 1);
    chk("b3_sent", words_sent, 1);
    chk("b3_lsb_sent", words_sent_l, 1);
    chk_stream("b3");
    do_reset;
    send(8'h01);
    send(8'h80);
    wait_idle;
    chk_stream("b2b");
    chk("b2b_count", cq.size(), 16);
    if (cq.size() == 16) chk("b2b_gapless", cq[15] - cq[0], 15);
    chk("b2b_sent", words_sent, 2);
    do_reset;
    send(8'hF0);
    tick;
    tick;
    tick;
    tick;
    ser_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", ser_valid, 0);
      chk("stall_out", ser_out, 1);
      chk("stall_busy", busy, 1);
      tick;
    end
    ser_en = 1'b1;
    wait_idle;
    chk_stream("stall");
    if (cq.size() == 8) chk("stall_gap", cq[3] - cq[2], 4);
    chk("stall_sent", words_sent, 1);
    do_reset;
    ser_en = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'($urandom);
      if (in_ready) begin
        acc++;
        wq.push_back(in_data);
      end
      tick;
    end
    chk("fill_accepted", acc, 2);
    chk("fill_ready", in_ready, 0);
    in_valid = 1'b0;
    ser_en = 1'b1;
    wait_idle;
    chk_stream("fill");
    chk("fill_sent", words_sent, 2);
    do_reset;
    w = 8'hAA;
    send(w);
    send(8'h55);
    tick;
    tick;
    tick;
    chk("mid_bit4", ser_out, w[3]);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick;
    clr;
    chk("mid_rst_valid", ser_valid, 0);
    chk("mid_rst_out", ser_out, 1);
    chk("mid_rst_sent", words_sent, 0);
    chk("mid_rst_ready", in_ready, 0);
    reset = 1'b0;
    repeat (20) tick;
    chk("mid_no_bits", bq.size(), 0);
    chk("mid_sent_after", words_sent, 0);
    chk("mid_busy_after", busy, 0);
    do_reset;
    force dut.sent = 16'hFFFF;
    force dut_l.sent = 16'hFFFF;
    #1;
    release dut.sent;
    release dut_l.sent;
    chk("wrap_pre", words_sent, 16'hFFFF);
    send(8'hB3);
    wait_idle;
    chk("wrap_sent", words_sent, 0);
    chk("wrap_lsb_sent", words_sent_l, 0);
    chk_stream("wrap");
    do_reset;
    for (int i = 0; i < 500; i++) begin
      in_valid = $urandom_range(0, 2) != 0;
      in_data = 8'($urandom);
      ser_en = $urandom_range(0, 3) != 0;
      if (in_valid && in_ready) wq.push_back(in_data);
      tick;
      chk("rnd_busy", busy, wq.size() != int'(words_sent));
      chk("rnd_inflight", wq.size() - int'(words_sent) <= 2, 1);
    end
    in_valid = 1'b0;
    ser_en = 1'b1;
    wait_idle;
    chk_stream("rnd");
    chk("rnd_sent", words_sent, wq.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/par2ser_feeder.md
PAR2SER_FEEDER -- requirements
Module: par2ser_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (>=2).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 SHALL have parameter IDLE_BIT, default 1, the ser_out level when no word is shifting.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_data  input  WIDTH  parallel word to serialise.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  holding buffer can accept a word.
REQ-009 SHALL have port ser_en  input  1  downstream advance enable; 0 stalls shifting.
REQ-010 SHALL have port ser_out  output  1  serial bit to the downstream sequence detector.
REQ-011 SHALL have port ser_valid  output  1  ser_out carries a live bit this cycle.
REQ-012 SHALL have port busy  output  1  state is SHIFT or the holding buffer is full.
REQ-013 SHALL have port words_sent  output  16  count of fully shifted words.

Function
REQ-014 SHALL accept a word on a rising edge where in_valid=1 and in_ready=1, capturing in_data into a one-entry holding buffer.
REQ-015 SHALL drive in_ready = NOT buf_full, from registers only, with no combinational path from in_valid.
REQ-016 SHALL implement FSM states IDLE and SHIFT, plus a bit counter of clog2(WIDTH) bits.
REQ-017 In IDLE with buf_full=1, SHALL load the shifter from the buffer, clear buf_full, set the bit counter to 0 and enter SHIFT on that edge.
REQ-018 SHALL present the first bit of a word on ser_out, with ser_valid=1, two cycles after its acceptance edge when the FSM was IDLE and ser_en=1.
REQ-019 In SHIFT, ser_valid SHALL equal ser_en, and each edge with ser_en=1 SHALL advance one bit in the order set by MSB_FIRST.
REQ-020 With ser_en=0, SHALL hold ser_out at the current bit and freeze the counter and shifter.
REQ-021 On the edge emitting bit WIDTH-1 with ser_en=1, SHALL increment words_sent; the count wraps from 0xFFFF to 0x0000.
REQ-022 On that same final-bit edge, if buf_full=1 SHALL reload the shifter and stay in SHIFT, giving gapless streaming; otherwise SHALL go to IDLE.
REQ-023 Acceptance and buffer-to-shifter transfer on the same edge SHALL both take effect, leaving the buffer holding the new word.
REQ-024 In IDLE, ser_out SHALL be IDLE_BIT and ser_valid SHALL be 0.

Reset
REQ-025 While reset=1 SHALL hold in_ready=0; after reset deasserts, in_ready SHALL be 1.
REQ-026 Reset SHALL set state to IDLE, buf_full=0, counter=0, words_sent=0, ser_out=IDLE_BIT, ser_valid=0 and busy=0.
REQ-027 Reset mid-word SHALL discard the partial and buffered words, emit no further bits from them and not count them.

Structure
REQ-028 A shared package SHALL hold the FSM state type (IDLE, SHIFT) and the default constants WIDTH=8 and IDLE_BIT=1.
REQ-029 The holding buffer SHALL be one sub-module, p2s_hold_reg (data register + full flag, load/take controls); the FSM and shifter SHALL stay in the top.

Verification
REQ-030 Accept 8'hB3 from IDLE with ser_en=1 -> ser_out = 1,0,1,1,0,0,1,1 on 8 consecutive ser_valid cycles starting 2 cycles after acceptance; words_sent=1; then IDLE with ser_out=1.
REQ-031 Accept 8'h01 then 8'h80 back-to-back -> 16 contiguous ser_valid cycles with bits 00000001 10000000 and no gap; words_sent=2.
REQ-032 Accept 8'hF0, drop ser_en for 3 cycles after bit 2 -> ser_valid=0 and ser_out held at 1 for 3 cycles; the word then completes with 1,0,0,0,0 on the remaining 5 valid cycles.
REQ-033 Drive in_valid=1 continuously while ser_en=0 -> exactly two words accepted (shifter + buffer), then in_ready=0 until shifting resumes.
REQ-034 Assert reset at bit 4 of 8'hAA with 8'h55 buffered -> the next cycle shows ser_valid=0, ser_out=1, words_sent=0, in_ready=0; 8'h55 is never emitted.
REQ-035 Preload words_sent to 0xFFFF via 65535 words, or force it in simulation, then complete one word -> words_sent=0x0000; repeat with MSB_FIRST=0 and 8'hB3 -> bits 1,1,0,0,1,1,0,1.
